// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//   Zero-wait-state APB slave with a small register file:
//     0..11  read/write storage
//     12     ID      (read-only, returns ID_VALUE)
//     13     WCNT    (read-only, counts committed writes to 0..11, wraps)
//     14     STATUS  (write-1-to-clear; bit0 PROTO_ERR, bit1 LAST_ERR)
//     15     unmapped (every access is an error, reads return 0)
//
// Ports
//   pclk     in   clock, all state on the rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   register address   [AWIDTH-1:0]
//   pwdata   in   write data         [DWIDTH-1:0]
//   prdata   out  registered read data [DWIDTH-1:0]
//   pready   out  transfer complete (combinational)
//   pslverr  out  transfer error, only while pready = 1
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int                AWIDTH   = 4,
  parameter int                DWIDTH   = 8,
  parameter logic [DWIDTH-1:0] ID_VALUE = 8'hA5
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AWIDTH-1:0] paddr,
  input  logic [DWIDTH-1:0] pwdata,
  output logic [DWIDTH-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] ADDR_ID     = AWIDTH'(12);
  localparam logic [AWIDTH-1:0] ADDR_WCNT   = AWIDTH'(13);
  localparam logic [AWIDTH-1:0] ADDR_STATUS = AWIDTH'(14);
  localparam logic [AWIDTH-1:0] ADDR_UNMAP  = AWIDTH'(15);

  state_t            state_q;
  logic [DWIDTH-1:0] regs_q [0:11];
  logic [DWIDTH-1:0] wcnt_q;
  logic              proto_err_q;
  logic              last_err_q;
  logic              err_q;
  logic [DWIDTH-1:0] prdata_q;

  logic              setup_entry;
  logic              proto_err_d;
  logic              commit;
  logic              err_d;
  logic [DWIDTH-1:0] rdata_d;
  logic [DWIDTH-1:0] status_rd;

  always_comb begin
    setup_entry = psel & ~penable;
    pready      = psel & penable & (state_q == SETUP);
    pslverr     = pready & err_q;
    // psel+penable without a preceding setup cycle
    proto_err_d = psel & penable & (state_q != SETUP);
    commit      = pready & pwrite & ~err_q;

    err_d = (paddr == ADDR_UNMAP) |
            (pwrite & ((paddr == ADDR_ID) | (paddr == ADDR_WCNT)));

    status_rd = {{(DWIDTH-2){1'b0}}, last_err_q, proto_err_q};

    rdata_d = '0;
    if (paddr < ADDR_ID)            rdata_d = regs_q[paddr];
    else if (paddr == ADDR_ID)      rdata_d = ID_VALUE;
    else if (paddr == ADDR_WCNT)    rdata_d = wcnt_q;
    else if (paddr == ADDR_STATUS)  rdata_d = status_rd;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      for (int i = 0; i < 12; i++) regs_q[i] <= '0;
      wcnt_q      <= '0;
      proto_err_q <= 1'b0;
      last_err_q  <= 1'b0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
    end else begin
      // A protocol-error cycle and a psel drop both fall through to IDLE.
      if (setup_entry)                           state_q <= SETUP;
      else if (psel && penable && state_q == SETUP) state_q <= ACCESS;
      else                                       state_q <= IDLE;

      // Decode is captured once, at setup entry, and held for the access.
      if (setup_entry) begin
        err_q <= err_d;
        if (!pwrite) prdata_q <= rdata_d;
      end

      if (commit && paddr < ADDR_ID) begin
        regs_q[paddr] <= pwdata;
        wcnt_q        <= wcnt_q + DWIDTH'(1);
      end

      // Set has priority over a coincident write-1-to-clear.
      proto_err_q <= proto_err_d |
                     (proto_err_q & ~(commit & (paddr == ADDR_STATUS) & pwdata[0]));

      // A completed transfer overwrites LAST_ERR with its own error status;
      // a clearing write to STATUS is itself error-free, so it lands as 0.
      if (pready) last_err_q <= err_q;
    end
  end

  assign prdata = prdata_q;

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 4, meaning APB address width; the register map below is fixed for AWIDTH = 4.
REQ-002 The block SHALL have parameter DWIDTH, default 8, meaning APB data width and the width of every register.
REQ-003 The block SHALL have parameter ID_VALUE, default 8'hA5, meaning the constant returned by the ID register.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: pclk input 1 (clock, all state on rising edge), presetn input 1 (asynchronous, active-low reset).
REQ-005 The block SHALL have port psel, input, 1 bit: slave select.
REQ-006 The block SHALL have port penable, input, 1 bit: access phase.
REQ-007 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port paddr, input, AWIDTH bits: register address.
REQ-009 The block SHALL have port pwdata, input, DWIDTH bits: write data.
REQ-010 The block SHALL have port prdata, output, DWIDTH bits: read data, registered.
REQ-011 The block SHALL have port pready, output, 1 bit: transfer complete.
REQ-012 The block SHALL have port pslverr, output, 1 bit: transfer error, valid while pready = 1.

Function
REQ-013 The register map SHALL be: addr 0-11 RW storage; 12 ID (RO, ID_VALUE); 13 WCNT (RO); 14 STATUS (W1C); 15 unmapped.
REQ-014 The block SHALL hold a registered FSM with states IDLE, SETUP, ACCESS, updated each rising edge of pclk from the sampled bus.
REQ-015 FSM transitions SHALL be:
- any state -> SETUP on psel=1, penable=0;
- SETUP -> ACCESS on psel=1, penable=1;
- ACCESS -> IDLE on psel=0;
- IDLE -> IDLE on psel=0.
REQ-016 The block SHALL be zero-wait-state: pready = psel & penable & (state == SETUP), combinational.
REQ-017 Address decode and error classification SHALL be registered at the SETUP-entry edge (psel=1, penable=0).
REQ-018 Error transfers SHALL be:
- any access to addr 15;
- writes to addr 12 or 13.
REQ-019 pslverr SHALL equal pready AND the registered error flag, and SHALL be 0 whenever pready = 0.
REQ-020 For reads, prdata SHALL load the addressed register at the SETUP-entry edge and hold until the next read SETUP-entry edge, so it is stable throughout the access phase and at the edge that ends it.
REQ-021 prdata SHALL be loaded with 0 for reads of addr 15.
REQ-022 Writes SHALL commit at the rising edge where pready = 1 and pwrite = 1, using pwdata and paddr sampled at that edge.
REQ-023 An error write SHALL leave all registers unchanged.
REQ-024 WCNT SHALL increment by 1 on each committed write to addr 0-11 only, wrapping 8'hFF -> 8'h00.
REQ-025 STATUS bit0 (PROTO_ERR) SHALL be set, sticky, when penable=1 and psel=1 are sampled in state IDLE or ACCESS (access without setup).
REQ-026 Such a protocol-error cycle SHALL not commit, SHALL not assert pready, and SHALL leave the FSM in IDLE.
REQ-027 STATUS bit1 (LAST_ERR) SHALL be updated at every completed transfer with that transfer's pslverr value.
REQ-028 STATUS SHALL be cleared by writing 1s: pwdata bit0 clears PROTO_ERR and pwdata bit1 clears LAST_ERR; when a set event and a clear coincide on the same edge, the set SHALL win.
REQ-029 STATUS bits 7:2 SHALL read 0.
REQ-030 A mid-transfer psel drop (psel=0 in SETUP) SHALL return the FSM to IDLE with no commit and no error.

Reset
REQ-031 While presetn = 0, regardless of pclk:
- state SHALL be IDLE;
- registers 0-11, WCNT and STATUS SHALL be 0;
- prdata SHALL be 0, and pready and pslverr SHALL be 0.
REQ-032 Assertion of presetn during an access phase SHALL abort the transfer with no commit.
REQ-033 After presetn is deasserted, the block SHALL accept a SETUP on the first rising edge.

Verification
REQ-034 The bench SHALL cover: write 8'h3C to addr 5, read addr 5 -> prdata = 8'h3C at the access-end edge, pslverr = 0, WCNT = 1.
REQ-035 The bench SHALL cover: read addr 12 -> 8'hA5; write 8'h00 to addr 12 -> pslverr = 1 during access, ID unchanged, STATUS = 8'h02.
REQ-036 The bench SHALL cover: read addr 15 -> prdata = 0 and pslverr = 1.
REQ-037 The bench SHALL cover: 256 writes to addr 0 -> WCNT = 8'h00; a 257th write -> WCNT = 8'h01.
REQ-038 The bench SHALL cover: drive psel=1, penable=1 with no setup cycle -> no commit, pready stays 0, STATUS bit0 = 1; write 8'h01 to addr 14 -> STATUS bit0 = 0.
REQ-039 The bench SHALL cover: assert presetn low mid-access of a write of 8'hFF to addr 3 -> addr 3 reads 0 and WCNT = 0 after reset.
